// File: rtl/bomba_pkg.sv
// Shared encodings and widths for the bomb game blocks (password checker, display driver).
package bomba_pkg;

  localparam int unsigned WIDTH_DEF = 7;
  localparam int unsigned TIME_W    = 8;
  localparam int unsigned TRIES_W   = 3;
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] ST_ARMED    = 2'd1;
  localparam logic [ST_W-1:0] ST_DEFUSED  = 2'd2;
  localparam logic [ST_W-1:0] ST_EXPLODED = 2'd3;

endpackage

// File: rtl/verificador_senha_if.sv
// Player/generator-facing bundle of the password checker: arm/guess inputs and game status outputs.
interface verificador_senha_if
  import bomba_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic               start;
  logic [WIDTH-1:0]   senha;
  logic [WIDTH-1:0]   guess;
  logic               submit;
  logic               armed;
  logic               defused;
  logic               exploded;
  logic [TIME_W-1:0]  time_left;
  logic [TRIES_W-1:0] tries_left;
  logic               hint_gt;
  logic               hint_lt;

  modport master (
    output start, senha, guess, submit,
    input  armed, defused, exploded, time_left, tries_left, hint_gt, hint_lt
  );

  modport slave (
    input  start, senha, guess, submit,
    output armed, defused, exploded, time_left, tries_left, hint_gt, hint_lt
  );
endinterface

// File: rtl/detector_borda.sv
// Registered rising-edge detector; the pulse appears one cycle after the edge is sampled.
module detector_borda (
  input  logic clk_1Hz,
  input  logic reset_n,
  input  logic sinal,
  input  logic habilita,
  output logic borda
);

  logic sinal_q;

  // History register runs in every state; habilita only qualifies the pulse.
  always_ff @(posedge clk_1Hz) begin
    if (!reset_n) begin
      sinal_q <= 1'b0;
      borda   <= 1'b0;
    end else begin
      sinal_q <= sinal;
      borda   <= sinal & ~sinal_q & habilita;
    end
  end

endmodule

// File: rtl/verificador_senha.sv
// Bomb defuse checker: latches the password on arm, runs fuse timer and tries counter.
// Optional build macro VERIFICADOR_HINT_EN enables registered greater/less hints.
module verificador_senha
  import bomba_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned TIME_LIMIT = 60,
  parameter int unsigned MAX_TRIES  = 3
) (
  input logic               clk_1Hz,
  input logic               reset_n,
  verificador_senha_if.slave bus
);

  logic [ST_W-1:0]    state_q, state_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [WIDTH-1:0]   senha_q, senha_d;
  logic               submit_rise;
  logic               match;
  logic               arming;

  // Rises seen outside ARMED never reach the game logic.
  detector_borda u_borda (
    .clk_1Hz  (clk_1Hz),
    .reset_n  (reset_n),
    .sinal    (bus.submit),
    .habilita (state_q == ST_ARMED),
    .borda    (submit_rise)
  );

  assign match  = (bus.guess == senha_q);
  assign arming = (state_q == ST_IDLE) && bus.start;

  // Next state and counters; guess checks outrank the fuse so a last-second defuse wins.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tries_d = tries_q;
    senha_d = senha_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ARMED;
          senha_d = bus.senha;
          time_d  = TIME_W'(TIME_LIMIT);
          tries_d = TRIES_W'(MAX_TRIES);
        end
      end
      ST_ARMED: begin
        if (submit_rise && match) begin
          state_d = ST_DEFUSED;
        end else if (submit_rise && (tries_q == TRIES_W'(1))) begin
          state_d = ST_EXPLODED;
          tries_d = '0;
        end else if (time_q == TIME_W'(1)) begin
          state_d = ST_EXPLODED;
          time_d  = '0;
        end else begin
          time_d = time_q - TIME_W'(1);
          if (submit_rise) tries_d = tries_q - TRIES_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1Hz) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      time_q  <= TIME_W'(TIME_LIMIT);
      tries_q <= TRIES_W'(MAX_TRIES);
      senha_q <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      tries_q <= tries_d;
      senha_q <= senha_d;
    end
  end

`ifdef VERIFICADOR_HINT_EN
  logic hint_gt_q, hint_lt_q;

  // Hints describe the most recent wrong guess and are wiped on every new game.
  always_ff @(posedge clk_1Hz) begin
    if (!reset_n || arming) begin
      hint_gt_q <= 1'b0;
      hint_lt_q <= 1'b0;
    end else if ((state_q == ST_ARMED) && submit_rise && !match) begin
      hint_gt_q <= (bus.guess > senha_q);
      hint_lt_q <= (bus.guess < senha_q);
    end
  end

  assign bus.hint_gt = hint_gt_q;
  assign bus.hint_lt = hint_lt_q;
`else
  assign bus.hint_gt = 1'b0;
  assign bus.hint_lt = 1'b0;
`endif

  assign bus.armed      = (state_q == ST_ARMED);
  assign bus.defused    = (state_q == ST_DEFUSED);
  assign bus.exploded   = (state_q == ST_EXPLODED);
  assign bus.time_left  = time_q;
  assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_verificador_senha.sv
// Self-checking bench for verificador_senha: directed game scenarios plus randomized play
// checked against a game-rule reference model.
module tb_verificador_senha;

  localparam int TL = 60;
  localparam int MT = 3;

  localparam int G_IDLE = 0;
  localparam int G_ARMED = 1;
  localparam int G_DEFUSED = 2;
  localparam int G_EXPLODED = 3;

  logic clk_1Hz = 1'b0;
  logic reset_n = 1'b0;

  verificador_senha_if #(.WIDTH(7)) bus ();

  verificador_senha #(.WIDTH(7), .TIME_LIMIT(TL), .MAX_TRIES(MT)) dut (
    .clk_1Hz (clk_1Hz),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  int tests = 0;
  int errs  = 0;

  // Reference game state
  int       g_phase;
  int       g_secs;
  int       g_tries;
  logic [6:0] g_pw;
  bit       g_btn_prev;
  bit       g_press_pending;
  bit       g_gt, g_lt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Game rules applied once per second, given the inputs present at that tick.
  task automatic model_tick();
    bit press_now;
    if (!reset_n) begin
      g_phase = G_IDLE; g_secs = TL; g_tries = MT; g_pw = '0;
      g_btn_prev = 0; g_press_pending = 0; g_gt = 0; g_lt = 0;
      return;
    end
    press_now = bus.submit && !g_btn_prev && (g_phase == G_ARMED);
    if (g_phase == G_IDLE && bus.start) begin
      g_phase = G_ARMED; g_pw = bus.senha; g_secs = TL; g_tries = MT;
      g_gt = 0; g_lt = 0;
    end else if (g_phase == G_ARMED) begin
      if (g_press_pending && bus.guess == g_pw) begin
        g_phase = G_DEFUSED;
      end else begin
`ifdef VERIFICADOR_HINT_EN
        if (g_press_pending) begin
          g_gt = (int'(bus.guess) > int'(g_pw));
          g_lt = (int'(bus.guess) < int'(g_pw));
        end
`endif
        if (g_press_pending && g_tries == 1) begin
          g_phase = G_EXPLODED; g_tries = 0;
        end else if (g_secs == 1) begin
          g_phase = G_EXPLODED; g_secs = 0;
        end else begin
          g_secs = g_secs - 1;
          if (g_press_pending) g_tries = g_tries - 1;
        end
      end
    end
    g_btn_prev = bus.submit;
    g_press_pending = press_now;
  endtask

  task automatic compare_all();
    check_eq("armed",      32'(bus.armed),      32'(g_phase == G_ARMED));
    check_eq("defused",    32'(bus.defused),    32'(g_phase == G_DEFUSED));
    check_eq("exploded",   32'(bus.exploded),   32'(g_phase == G_EXPLODED));
    check_eq("time_left",  32'(bus.time_left),  32'(g_secs));
    check_eq("tries_left", 32'(bus.tries_left), 32'(g_tries));
    check_eq("hint_gt",    32'(bus.hint_gt),    32'(g_gt));
    check_eq("hint_lt",    32'(bus.hint_lt),    32'(g_lt));
  endtask

  task automatic step();
    @(posedge clk_1Hz);
    model_tick();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bus.start = 0; bus.submit = 0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic arm(input logic [6:0] pw);
    bus.start = 1; bus.senha = pw;
    step();
    bus.start = 0;
  endtask

  task automatic press(input int hold);
    bus.submit = 1;
    repeat (hold) step();
    bus.submit = 0;
    step();
  endtask

  initial begin
    bus.start = 0; bus.senha = '0; bus.guess = '0; bus.submit = 0;
    reset_n = 1'b0;

    // Reset values
    do_reset();
    check_eq("rst_time", 32'(bus.time_left), 32'd60);
    check_eq("rst_tries", 32'(bus.tries_left), 32'd3);
    check_eq("rst_armed", 32'(bus.armed), 32'd0);

    // Correct guess after five armed seconds
    arm(7'h55);
    check_eq("t1_armed", 32'(bus.armed), 32'd1);
    repeat (4) step();
    bus.guess = 7'h55; bus.submit = 1;
    step();
    step();
    check_eq("t1_defused", 32'(bus.defused), 32'd1);
    check_eq("t1_time", 32'(bus.time_left), 32'd55);
    check_eq("t1_tries", 32'(bus.tries_left), 32'd3);
    bus.submit = 0;
    repeat (3) step();
    check_eq("t1_sticky", 32'(bus.defused), 32'd1);

    // Three wrong guesses, first one held for four cycles
    do_reset();
    arm(7'h55);
    bus.guess = 7'h00;
    press(4);
    check_eq("t2_tries2", 32'(bus.tries_left), 32'd2);
    press(1);
    check_eq("t2_tries1", 32'(bus.tries_left), 32'd1);
    press(1);
    check_eq("t2_exploded", 32'(bus.exploded), 32'd1);
    check_eq("t2_tries0", 32'(bus.tries_left), 32'd0);

    // Fuse runs out exactly TIME_LIMIT seconds after arm
    do_reset();
    arm(7'h11);
    repeat (TL - 1) step();
    check_eq("t3_not_yet", 32'(bus.exploded), 32'd0);
    check_eq("t3_time1", 32'(bus.time_left), 32'd1);
    step();
    check_eq("t3_exploded", 32'(bus.exploded), 32'd1);
    check_eq("t3_time0", 32'(bus.time_left), 32'd0);

    // Correct guess decided on the last second beats the fuse
    do_reset();
    arm(7'h55);
    bus.guess = 7'h55;
    repeat (TL - 2) step();
    bus.submit = 1;
    step();
    step();
    check_eq("t4_defused", 32'(bus.defused), 32'd1);
    check_eq("t4_not_expl", 32'(bus.exploded), 32'd0);
    check_eq("t4_time", 32'(bus.time_left), 32'd1);
    bus.submit = 0;

    // Password ignores later generator changes; mid-game reset aborts
    do_reset();
    arm(7'h55);
    bus.senha = 7'h2A;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_eq("t5_rst_armed", 32'(bus.armed), 32'd0);
    check_eq("t5_rst_time", 32'(bus.time_left), 32'd60);
    bus.senha = 7'h55;
    arm(7'h55);
    bus.senha = 7'h2A; bus.guess = 7'h55;
    step();
    press(1);
    check_eq("t5_defused", 32'(bus.defused), 32'd1);

    // Hints on wrong guesses
    do_reset();
    arm(7'h40);
    bus.guess = 7'h50;
    press(1);
`ifdef VERIFICADOR_HINT_EN
    check_eq("t6_gt_hi", 32'(bus.hint_gt), 32'd1);
    check_eq("t6_lt_hi", 32'(bus.hint_lt), 32'd0);
`else
    check_eq("t6_gt_off", 32'(bus.hint_gt), 32'd0);
    check_eq("t6_lt_off", 32'(bus.hint_lt), 32'd0);
`endif
    bus.guess = 7'h10;
    press(1);
`ifdef VERIFICADOR_HINT_EN
    check_eq("t6_gt_lo", 32'(bus.hint_gt), 32'd0);
    check_eq("t6_lt_lo", 32'(bus.hint_lt), 32'd1);
`else
    check_eq("t6_gt_off2", 32'(bus.hint_gt), 32'd0);
    check_eq("t6_lt_off2", 32'(bus.hint_lt), 32'd0);
`endif

    // Randomized play
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset_n    = ($urandom_range(0, 79) != 0);
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.senha  = 7'($urandom);
      bus.guess  = ($urandom_range(0, 3) == 0) ? g_pw : 7'($urandom);
      bus.submit = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
